// File: rtl/ball_ctl.sv
// ---------------------------------------------------------------------------
// ball_ctl -- per-frame ball motion controller for the pong field.
//
// Once per frame, on the rising edge of vblnk, the ball is moved by `step`
// pixels on each axis. It bounces off the top and bottom walls and off both
// pad faces. When it leaves the field past a pad, the opposite player's
// score pulse fires for one clock. The ball then freezes for one frame and
// is re-served from the centre.
//
// Ports:
//   clk          in   pixel clock
//   rst          in   synchronous reset, active-low
//   vblnk        in   vertical blanking from the timing stage
//   game_en      in   when low, the ball stays parked at centre (SERVE)
//   y_pad_left   in   [9:0] left pad top edge
//   y_pad_right  in   [9:0] right pad top edge
//   x_ball       out  [9:0] ball left edge, registered
//   y_ball       out  [9:0] ball top edge, registered
//   score_left   out  one-cycle pulse, left player scores (ball exits right)
//   score_right  out  one-cycle pulse, right player scores (ball exits left)
//
// Build option:
//   BALL_SPEEDUP_EN  when defined, each pad hit raises the step by one,
//                    saturating at STEP_MAX; otherwise the step stays at
//                    STEP_INIT.
// ---------------------------------------------------------------------------
module ball_ctl #(
    parameter int HOR_PIXELS   = 1024,
    parameter int VER_PIXELS   = 768,
    parameter int BALL_SIZE    = 15,
    parameter int PAD_L_X      = 30,
    parameter int PAD_R_X      = 979,
    parameter int PAD_WIDTH    = 15,
    parameter int PAD_HIGHT    = 145,
    parameter int STEP_INIT    = 2,
    parameter int STEP_MAX     = 6,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblnk,
    input  logic       game_en,
    input  logic [9:0] y_pad_left,
    input  logic [9:0] y_pad_right,
    output logic [9:0] x_ball,
    output logic [9:0] y_ball,
    output logic       score_left,
    output logic       score_right
);

    typedef enum logic [1:0] {
        SERVE  = 2'd0,
        MOVE   = 2'd1,
        SCORED = 2'd2
    } state_t;

    // Comparisons run 12 bits wide so sums such as y_pad + PAD_HIGHT or
    // x + BALL_SIZE + step can never wrap.
    localparam int AW     = 12;
    // The step never exceeds STEP_MAX, so the register is sized to it.
    localparam int STEP_W = (STEP_MAX < 1) ? 1 : $clog2(STEP_MAX + 1);
    // The serve counter runs 0 .. SERVE_FRAMES-1.
    localparam int CNT_W  = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES);

    localparam logic [9:0] CX     = 10'((HOR_PIXELS - BALL_SIZE) / 2);
    localparam logic [9:0] CY     = 10'((VER_PIXELS - BALL_SIZE) / 2);
    localparam logic [9:0] Y_BOT  = 10'(VER_PIXELS - 1 - BALL_SIZE);
    localparam logic [9:0] X_LHIT = 10'(PAD_L_X + PAD_WIDTH + 1);
    localparam logic [9:0] X_RHIT = 10'(PAD_R_X - BALL_SIZE - 1);

    localparam logic [AW-1:0] A_BALL   = AW'(BALL_SIZE);
    localparam logic [AW-1:0] A_PAD_H  = AW'(PAD_HIGHT);
    localparam logic [AW-1:0] A_L_FACE = AW'(PAD_L_X + PAD_WIDTH);
    localparam logic [AW-1:0] A_R_FACE = AW'(PAD_R_X);
    localparam logic [AW-1:0] A_X_LIM  = AW'(HOR_PIXELS - 1);
    localparam logic [AW-1:0] A_Y_LIM  = AW'(VER_PIXELS - 1);

    localparam logic [STEP_W-1:0] STEP_INIT_V = STEP_W'(STEP_INIT);
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(SERVE_FRAMES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [9:0]        x_q, x_d;
    logic [9:0]        y_q, y_d;
    logic              dx_q, dx_d;        // 1 = moving right
    logic              dy_q, dy_d;        // 1 = moving down
    logic [STEP_W-1:0] step_q, step_d;
    logic              score_l_q, score_l_d;
    logic              score_r_q, score_r_d;
    logic              vblnk_q;
    logic              armed_q;
    logic              tick;

    // Candidate results of one MOVE tick.
    logic [AW-1:0]     xa, ya, sa, pla, pra;
    logic [9:0]        step10;
    logic [9:0]        x_mv, y_mv;
    logic              dx_mv, dy_mv;
    logic              ov_l, ov_r;
    logic              hit, miss_l, miss_r;
    logic [STEP_W-1:0] step_hit;

    // armed_q blocks a tick until vblnk has been seen low after reset, so a
    // vblnk that is already high at reset release is not mistaken for a
    // rising edge.
    assign tick = vblnk & ~vblnk_q & armed_q;

    assign xa     = AW'(x_q);
    assign ya     = AW'(y_q);
    assign sa     = AW'(step_q);
    assign pla    = AW'(y_pad_left);
    assign pra    = AW'(y_pad_right);
    assign step10 = 10'(step_q);

    // Ball box overlaps the pad span in y (both spans inclusive).
    assign ov_l = (ya + A_BALL >= pla) && (ya <= pla + A_PAD_H);
    assign ov_r = (ya + A_BALL >= pra) && (ya <= pra + A_PAD_H);

`ifdef BALL_SPEEDUP_EN
    localparam logic [STEP_W-1:0] STEP_MAX_V = STEP_W'(STEP_MAX);
    assign step_hit = (step_q >= STEP_MAX_V) ? STEP_MAX_V : step_q + STEP_W'(1);
`else
    assign step_hit = step_q;
`endif

    // Axis checks use the pre-update position and are independent, so a
    // corner produces a wall bounce and a pad bounce on the same tick.
    always_comb begin
        y_mv   = y_q;
        dy_mv  = dy_q;
        x_mv   = x_q;
        dx_mv  = dx_q;
        hit    = 1'b0;
        miss_l = 1'b0;
        miss_r = 1'b0;

        if (!dy_q) begin
            if (ya <= sa) begin
                y_mv  = 10'd0;
                dy_mv = 1'b1;
            end else begin
                y_mv = y_q - step10;
            end
        end else begin
            if (ya + A_BALL + sa >= A_Y_LIM) begin
                y_mv  = Y_BOT;
                dy_mv = 1'b0;
            end else begin
                y_mv = y_q + step10;
            end
        end

        // A pad only catches a ball still in front of its face; once past
        // the face the ball keeps going until it leaves the field.
        if (!dx_q) begin
            if ((xa <= A_L_FACE + sa) && (xa > A_L_FACE) && ov_l) begin
                x_mv  = X_LHIT;
                dx_mv = 1'b1;
                hit   = 1'b1;
            end else if (xa <= sa) begin
                miss_l = 1'b1;
            end else begin
                x_mv = x_q - step10;
            end
        end else begin
            if ((xa + A_BALL + sa >= A_R_FACE) && (xa + A_BALL < A_R_FACE) && ov_r) begin
                x_mv  = X_RHIT;
                dx_mv = 1'b0;
                hit   = 1'b1;
            end else if (xa + A_BALL + sa >= A_X_LIM) begin
                miss_r = 1'b1;
            end else begin
                x_mv = x_q + step10;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        step_d    = step_q;
        score_l_d = 1'b0;
        score_r_d = 1'b0;

        if (tick) begin
            case (state_q)
                SERVE: begin
                    if (!game_en) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        step_d  = STEP_INIT_V;
                        state_d = MOVE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                MOVE: begin
                    // On a miss the ball stays where it was; dx is left
                    // pointing at the player who conceded, which is the
                    // direction of the next serve.
                    if (miss_l) begin
                        score_r_d = 1'b1;
                        dx_d      = 1'b0;
                        state_d   = SCORED;
                    end else if (miss_r) begin
                        score_l_d = 1'b1;
                        dx_d      = 1'b1;
                        state_d   = SCORED;
                    end else begin
                        x_d  = x_mv;
                        y_d  = y_mv;
                        dx_d = dx_mv;
                        dy_d = dy_mv;
                        if (hit) begin
                            step_d = step_hit;
                        end
                    end
                end
                SCORED: begin
                    x_d     = CX;
                    y_d     = CY;
                    cnt_d   = '0;
                    state_d = SERVE;
                end
                default: begin
                    state_d = SERVE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= SERVE;
            cnt_q     <= '0;
            x_q       <= CX;
            y_q       <= CY;
            dx_q      <= 1'b1;
            dy_q      <= 1'b1;
            step_q    <= STEP_INIT_V;
            score_l_q <= 1'b0;
            score_r_q <= 1'b0;
            vblnk_q   <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            step_q    <= step_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            vblnk_q   <= vblnk;
            armed_q   <= armed_q | ~vblnk;
        end
    end

    assign x_ball      = x_q;
    assign y_ball      = y_q;
    assign score_left  = score_l_q;
    assign score_right = score_r_q;

endmodule

// File: tb/tb_ball_ctl.sv
`timescale 1ns/1ps
module tb_ball_ctl;

    localparam int HOR = 1024;
    localparam int VER = 768;
    localparam int BS  = 15;
    localparam int PLX = 30;
    localparam int PRX = 979;
    localparam int PW  = 15;
    localparam int PH  = 145;
    localparam int SI  = 2;
    localparam int SM  = 6;
    localparam int SF  = 60;
    localparam int CX  = (HOR - BS) / 2;
    localparam int CY  = (VER - BS) / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vblnk = 1'b0;
    logic       game_en = 1'b0;
    logic [9:0] y_pad_left = 10'd0;
    logic [9:0] y_pad_right = 10'd0;
    logic [9:0] x_ball, y_ball;
    logic       score_left, score_right;

    ball_ctl #(
        .HOR_PIXELS(HOR), .VER_PIXELS(VER), .BALL_SIZE(BS),
        .PAD_L_X(PLX), .PAD_R_X(PRX), .PAD_WIDTH(PW), .PAD_HIGHT(PH),
        .STEP_INIT(SI), .STEP_MAX(SM), .SERVE_FRAMES(SF)
    ) dut (
        .clk(clk), .rst(rst), .vblnk(vblnk), .game_en(game_en),
        .y_pad_left(y_pad_left), .y_pad_right(y_pad_right),
        .x_ball(x_ball), .y_ball(y_ball),
        .score_left(score_left), .score_right(score_right)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    // Game-level model: phase 0 = waiting at centre, 1 = in play,
    // 2 = frozen after a miss.
    typedef struct packed {
        int x;
        int y;
        int step;
        int phase;
        int held;
        bit right;
        bit down;
        bit vq;
        bit seen_low;
        bit sl;
        bit sr;
    } ms_t;

    ms_t m;

    function automatic ms_t m_reset();
        ms_t r;
        r.x = CX; r.y = CY; r.step = SI; r.phase = 0; r.held = 0;
        r.right = 1'b1; r.down = 1'b1; r.vq = 1'b0; r.seen_low = 1'b0;
        r.sl = 1'b0; r.sr = 1'b0;
        return r;
    endfunction

    function automatic ms_t model_next(ms_t s, logic r, logic vb, logic ge, int pl, int pr);
        ms_t n;
        int  nx, ny;
        bit  hit, gone;
        if (!r) return m_reset();
        n = s;
        n.sl = 1'b0;
        n.sr = 1'b0;
        n.vq = vb;
        if (!vb) n.seen_low = 1'b1;
        if (!(vb && !s.vq && s.seen_low)) return n;
        if (s.phase == 0) begin
            if (!ge) n.held = 0;
            else if (s.held + 1 >= SF) begin
                n.held = 0; n.step = SI; n.phase = 1;
            end else n.held = s.held + 1;
        end else if (s.phase == 2) begin
            n.x = CX; n.y = CY; n.phase = 0;
        end else begin
            if (s.down) begin
                ny = s.y + s.step;
                if (ny + BS >= VER - 1) begin ny = VER - 1 - BS; n.down = 1'b0; end
            end else begin
                ny = s.y - s.step;
                if (ny <= 0) begin ny = 0; n.down = 1'b1; end
            end
            hit = 1'b0;
            gone = 1'b0;
            if (s.right) begin
                nx = s.x + s.step;
                if (nx + BS >= PRX && s.x + BS < PRX && s.y + BS >= pr && s.y <= pr + PH) begin
                    nx = PRX - BS - 1; n.right = 1'b0; hit = 1'b1;
                end else if (nx + BS >= HOR - 1) gone = 1'b1;
            end else begin
                nx = s.x - s.step;
                if (nx <= PLX + PW && s.x > PLX + PW && s.y + BS >= pl && s.y <= pl + PH) begin
                    nx = PLX + PW + 1; n.right = 1'b1; hit = 1'b1;
                end else if (nx <= 0) gone = 1'b1;
            end
            if (gone) begin
                n.phase = 2;
                if (s.right) n.sl = 1'b1; else n.sr = 1'b1;
            end else begin
                n.x = nx;
                n.y = ny;
`ifdef BALL_SPEEDUP_EN
                if (hit && s.step < SM) n.step = s.step + 1;
`endif
            end
        end
        return n;
    endfunction

    always @(posedge clk)
        m <= model_next(m, rst, vblnk, game_en, int'(y_pad_left), int'(y_pad_right));

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Pins both the DUT and the model to a hand-computed value.
    task automatic lit(string name, logic [31:0] dut_v, int model_v, int exp);
        check({name, "_dut"}, dut_v, exp);
        check({name, "_model"}, model_v, exp);
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("x_ball", 32'(x_ball), m.x);
            check("y_ball", 32'(y_ball), m.y);
            check("score_left", 32'(score_left), 32'(m.sl));
            check("score_right", 32'(score_right), 32'(m.sr));
            check("score_excl", 32'(score_left & score_right), 32'd0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic frame(int hi, int lo);
        vblnk = 1'b1;
        repeat (hi) cyc();
        vblnk = 1'b0;
        repeat (lo) cyc();
    endtask

    task automatic frames(int n);
        repeat (n) frame(2, 3);
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) cyc();
        cmp_on = 1'b1;
        lit("rst_x", 32'(x_ball), m.x, 504);
        lit("rst_y", 32'(y_ball), m.y, 376);
        lit("rst_sl", 32'(score_left), int'(m.sl), 0);
        rst = 1'b1;
        cyc();

        frames(3);
        lit("park_x", 32'(x_ball), m.x, 504);
        lit("park_y", 32'(y_ball), m.y, 376);

        game_en = 1'b1;
        y_pad_left = 10'd0;
        y_pad_right = 10'd600;
        frames(60);
        lit("serve60_x", 32'(x_ball), m.x, 504);
        lit("serve60_y", 32'(y_ball), m.y, 376);
        frames(1);
        lit("move1_x", 32'(x_ball), m.x, 506);
        lit("move1_y", 32'(y_ball), m.y, 378);
        frames(187);
        lit("floor_x", 32'(x_ball), m.x, 880);
        lit("floor_y", 32'(y_ball), m.y, 752);
        frames(41);
        lit("prehit_x", 32'(x_ball), m.x, 962);
        lit("prehit_y", 32'(y_ball), m.y, 670);
        frames(1);
        lit("rhit_x", 32'(x_ball), m.x, 963);
        lit("rhit_y", 32'(y_ball), m.y, 668);
`ifndef BALL_SPEEDUP_EN
        frames(481);
        lit("premiss_x", 32'(x_ball), m.x, 1);
        lit("premiss_y", 32'(y_ball), m.y, 294);
        frames(1);
        lit("frozen_x", 32'(x_ball), m.x, 1);
        lit("frozen_y", 32'(y_ball), m.y, 294);
        frames(1);
        lit("reserve_x", 32'(x_ball), m.x, 504);
        lit("reserve_y", 32'(y_ball), m.y, 376);
        frames(61);
        lit("serve_left_x", 32'(x_ball), m.x, 502);
        lit("serve_left_y", 32'(y_ball), m.y, 378);
`endif

        for (int f = 0; f < 2500; f++) begin
            game_en = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 3) == 0) y_pad_left = 10'($urandom_range(0, 760));
            if ($urandom_range(0, 3) == 0) y_pad_right = 10'($urandom_range(0, 760));
            if ($urandom_range(0, 149) == 0) begin
                vblnk = 1'($urandom_range(0, 1));
                rst = 1'b0;
                repeat ($urandom_range(1, 3)) cyc();
                vblnk = 1'($urandom_range(0, 1));
                rst = 1'b1;
                repeat (2) cyc();
            end
            frame($urandom_range(1, 3), $urandom_range(1, 4));
        end

        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
